// File: rtl/module_led_sequencer.sv
// Parametrised LED pattern sequencer: a programmable prescaler produces step events
// that advance one of four patterns (binary, walking one, bounce, blink) on an N-bit LED bank.
module module_led_sequencer #(
  parameter int N_LEDS     = 6,
  parameter int COUNT      = 13500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic              dir_i,
  input  logic [1:0]        speed_i,
  output logic [N_LEDS-1:0] led_o,
  output logic              tick_o
);

  localparam int W = $clog2(COUNT);

  typedef enum logic [1:0] {
    MODE_BIN    = 2'b00,
    MODE_WALK   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef logic [N_LEDS-1:0] pat_t;

  mode_e       mode_q, mode_d;
  pat_t        pattern_q, pattern_d;
  logic        bounce_left_q, bounce_left_d;
  logic [W-1:0] presc_q, presc_d;
  logic        tick_q, tick_d;

  logic [31:0]  period;
  logic [W-1:0] limit;
  logic         mode_change;
  logic         step_due;
  pat_t         step_pat;
  logic         step_left;

  pat_t rot_left, rot_right, shl, shr;

  function automatic pat_t seed(input mode_e m);
    pat_t s;
    case (m)
      MODE_WALK, MODE_BOUNCE: s = pat_t'(1);
      default:                s = '0;
    endcase
    return s;
  endfunction

  // Limit is re-evaluated every cycle so a speed change applies immediately.
  assign period      = COUNT >> speed_i;
  assign limit       = W'(period - 32'd1);
  assign mode_change = (mode_i != mode_q);
  assign step_due    = (presc_q >= limit);

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_bits
    assign rot_left[gi]  = pattern_q[(gi + N_LEDS - 1) % N_LEDS];
    assign rot_right[gi] = pattern_q[(gi + 1) % N_LEDS];
    if (gi == 0) begin : g_shl_lsb
      assign shl[gi] = 1'b0;
    end else begin : g_shl_mid
      assign shl[gi] = pattern_q[gi-1];
    end
    if (gi == N_LEDS - 1) begin : g_shr_msb
      assign shr[gi] = 1'b0;
    end else begin : g_shr_mid
      assign shr[gi] = pattern_q[gi+1];
    end
  end

  always_comb begin
    step_pat  = pattern_q;
    step_left = bounce_left_q;
    case (mode_q)
      MODE_BIN: begin
        step_pat = dir_i ? pattern_q + pat_t'(1) : pattern_q - pat_t'(1);
      end
      MODE_WALK: begin
        step_pat = dir_i ? rot_left : rot_right;
      end
      MODE_BOUNCE: begin
        // A single LED has nowhere to bounce: the lit bit stays put.
        if (N_LEDS > 1) begin
          if (bounce_left_q) begin
            step_pat  = shl;
            step_left = ~shl[N_LEDS-1];
          end else begin
            step_pat  = shr;
            step_left = shr[0];
          end
        end
      end
      default: begin
        step_pat = ~pattern_q;
      end
    endcase
  end

  // Mode change outranks a coincident step and applies even while paused.
  always_comb begin
    mode_d        = mode_q;
    pattern_d     = pattern_q;
    bounce_left_d = bounce_left_q;
    presc_d       = presc_q;
    tick_d        = 1'b0;
    if (mode_change) begin
      mode_d        = mode_e'(mode_i);
      pattern_d     = seed(mode_e'(mode_i));
      bounce_left_d = 1'b1;
      presc_d       = '0;
    end else if (en_i) begin
      if (step_due) begin
        presc_d       = '0;
        tick_d        = 1'b1;
        pattern_d     = step_pat;
        bounce_left_d = step_left;
      end else begin
        presc_d = presc_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q        <= mode_e'(mode_i);
      pattern_q     <= seed(mode_e'(mode_i));
      bounce_left_q <= 1'b1;
      presc_q       <= '0;
      tick_q        <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      pattern_q     <= pattern_d;
      bounce_left_q <= bounce_left_d;
      presc_q       <= presc_d;
      tick_q        <= tick_d;
    end
  end

  if (ACTIVE_LOW) begin : g_pol_low
    assign led_o = ~pattern_q;
  end else begin : g_pol_high
    assign led_o = pattern_q;
  end

  assign tick_o = tick_q;

endmodule

// File: tb/tb_module_led_sequencer.sv
// Directed plus randomized bench for module_led_sequencer (N_LEDS=4, COUNT=8, ACTIVE_LOW=1),
// comparing led_o and tick_o every cycle against a position/phase-based reference model.
module tb_module_led_sequencer;

  localparam int N  = 4;
  localparam int CNT = 8;

  logic         clk;
  logic         rst;
  logic         en_i;
  logic [1:0]   mode_i;
  logic         dir_i;
  logic [1:0]   speed_i;
  logic [N-1:0] led_o;
  logic         tick_o;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  // Reference model: pattern described by value / lit position / bounce phase / blink parity.
  int m_mode;
  int m_val;
  int m_pos;
  int m_phase;
  int m_blink;
  int m_cnt;
  bit m_tick;

  module_led_sequencer #(.N_LEDS(N), .COUNT(CNT), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .dir_i(dir_i),
    .speed_i(speed_i), .led_o(led_o), .tick_o(tick_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_pattern();
    int p;
    int bpos;
    case (m_mode)
      0: p = m_val;
      1: p = 1 << m_pos;
      2: begin
        bpos = (m_phase < N) ? m_phase : (2 * N - 2 - m_phase);
        p = 1 << bpos;
      end
      default: p = m_blink ? ((1 << N) - 1) : 0;
    endcase
    return p;
  endfunction

  task automatic model_reseed(input int m);
    m_mode  = m;
    m_val   = 0;
    m_pos   = 0;
    m_phase = 0;
    m_blink = 0;
    m_cnt   = 0;
    m_tick  = 1'b0;
  endtask

  task automatic model_advance(input bit d);
    case (m_mode)
      0: m_val = d ? (m_val + 1) % (1 << N) : (m_val + (1 << N) - 1) % (1 << N);
      1: m_pos = d ? (m_pos + 1) % N : (m_pos + N - 1) % N;
      2: m_phase = (m_phase + 1) % (2 * N - 2);
      default: m_blink = 1 - m_blink;
    endcase
  endtask

  task automatic model_edge();
    if (!rst || int'(mode_i) != m_mode) begin
      model_reseed(int'(mode_i));
    end else if (en_i) begin
      if (m_cnt >= (CNT >> speed_i) - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        model_advance(dir_i);
      end else begin
        m_cnt  = m_cnt + 1;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_led;
    exp_led = ~(N'(model_pattern()));
    checks++;
    assert (led_o === exp_led) else begin
      failures++;
      $error("FAIL %s led_o observed=%b expected=%b", phase, led_o, exp_led);
    end
    checks++;
    assert (tick_o === m_tick) else begin
      failures++;
      $error("FAIL %s tick_o observed=%b expected=%b", phase, tick_o, m_tick);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic expect_const(input string tag, input logic [N-1:0] led_exp, input logic tick_exp);
    checks++;
    assert (led_o === led_exp && tick_o === tick_exp) else begin
      failures++;
      $error("FAIL %s observed led=%b tick=%b expected led=%b tick=%b",
             tag, led_o, tick_o, led_exp, tick_exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic d);
    rst = 1'b0; mode_i = m; dir_i = d; en_i = 1'b1; speed_i = 2'd0;
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en_i = 1'b1; mode_i = 2'b00; dir_i = 1'b1; speed_i = 2'd0;
    model_reseed(0);

    phase = "reset_bin_up";
    run(2);
    expect_const("reset_led_ones", 4'b1111, 1'b0);
    rst = 1'b1;
    run(7);
    expect_const("bin_no_tick_before_8", 4'b1111, 1'b0);
    run(1);
    expect_const("bin_first_step", 4'b1110, 1'b1);
    run(15 * 8);
    expect_const("bin_wrap_16_steps", 4'b1111, 1'b1);
    $display("step %s: 16 steps done", phase);

    phase = "bin_down";
    do_reset(2'b00, 1'b0);
    run(8);
    expect_const("bin_down_first", 4'b0000, 1'b1);
    run(8);
    $display("step %s: 2 steps done", phase);

    phase = "bounce";
    do_reset(2'b10, 1'b1);
    run(10 * 8);
    mode_i = 2'b00;
    run(4);
    mode_i = 2'b10;
    run(10 * 8);
    $display("step %s: 20 steps done", phase);

    phase = "speed_sweep";
    do_reset(2'b00, 1'b1);
    for (int s = 1; s < 4; s++) begin
      speed_i = 2'(s);
      run(16);
    end
    do_reset(2'b00, 1'b1);
    run(5);
    speed_i = 2'd3;
    run(1);
    expect_const("speed_switch_step", 4'b1110, 1'b1);
    run(6);
    $display("step %s: done", phase);

    phase = "pause";
    do_reset(2'b01, 1'b1);
    run(16);
    expect_const("walk_at_0100", 4'b1011, 1'b1);
    run(3);
    en_i = 1'b0;
    run(20);
    expect_const("pause_hold", 4'b1011, 1'b0);
    en_i = 1'b1;
    run(16);
    expect_const("resume_wrap", 4'b1110, 1'b0);
    dir_i = 1'b0;
    run(24);
    $display("step %s: done", phase);

    phase = "mode_coincident";
    do_reset(2'b00, 1'b1);
    run(7);
    mode_i = 2'b11;
    run(1);
    expect_const("coincident_drop", 4'b1111, 1'b0);
    run(7);
    expect_const("blink_not_yet", 4'b1111, 1'b0);
    run(1);
    expect_const("blink_on", 4'b0000, 1'b1);
    run(5);
    rst = 1'b0;
    mode_i = 2'b10;
    run(1);
    expect_const("mid_reset", 4'b1110, 1'b0);
    rst = 1'b1;
    run(20);
    $display("step %s: done", phase);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b0; else rst = 1'b1;
      if ($urandom_range(0, 99) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) speed_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) dir_i = ~dir_i;
      en_i = ($urandom_range(0, 9) != 0);
      cycle();
    end
    $display("step %s: 3000 cycles done", phase);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
